// File: rtl/usart_pkg.sv
// rtl/usart_pkg.sv - shared status layout, receiver states and pointer-width helper
package usart_pkg;

   localparam int ST_OVR    = 7;
   localparam int ST_FULL   = 6;
   localparam int ST_EMPTY  = 5;
   localparam int ST_CNT_HI = 4;
   localparam int ST_CNT_LO = 0;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_e;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/rx_fifo.sv
// rtl/rx_fifo.sv - synchronous first-word-fall-through FIFO with occupancy count
module rx_fifo
   import usart_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [4:0]       count,
   output logic [4:0]       count_next
);

   localparam int PW = clog2(DEPTH);
   localparam logic [PW-1:0] PTR_ONE = 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wptr_q, wptr_d;
   logic [PW-1:0]    rptr_q, rptr_d;
   logic [4:0]       count_q, count_d;
   logic             do_push, do_pop;

   assign full       = (count_q == 5'(DEPTH));
   assign empty      = (count_q == 5'd0);
   assign count      = count_q;
   assign count_next = count_d;
   assign rdata      = mem_q[rptr_q];

   // A pop in the same cycle frees the slot a push into a full FIFO needs.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (do_push) wptr_d = wptr_q + PTR_ONE;
      if (do_pop)  rptr_d = rptr_q + PTR_ONE;
      if (do_push && !do_pop)      count_d = count_q + 5'd1;
      else if (do_pop && !do_push) count_d = count_q - 5'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= wdata;
   end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 serial receiver, one-cycle rx_ready pulse per good frame
module uart_rx
   import usart_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        rx,
   input  logic [11:0] clk_per_bit,
   output logic        rx_ready,
   output logic [7:0]  rx_byte
);

   rx_state_e   state_q;
   logic [1:0]  sync_q;
   logic [11:0] cnt_q;
   logic [2:0]  bit_q;
   logic [7:0]  shift_q;
   logic        ready_q;
   logic [7:0]  byte_q;
   logic        rx_s;

   assign rx_s     = sync_q[1];
   assign rx_ready = ready_q;
   assign rx_byte  = byte_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RX_IDLE;
         sync_q  <= 2'b11;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         ready_q <= 1'b0;
         byte_q  <= '0;
      end else begin
         sync_q  <= {sync_q[0], rx};
         ready_q <= 1'b0;
         case (state_q)
            RX_IDLE: begin
               cnt_q <= '0;
               bit_q <= '0;
               if (!rx_s) state_q <= RX_START;
            end
            // Re-check the start bit at its midpoint to reject glitches.
            RX_START: begin
               if (cnt_q == (clk_per_bit >> 1)) begin
                  cnt_q   <= '0;
                  state_q <= rx_s ? RX_IDLE : RX_DATA;
               end else begin
                  cnt_q <= cnt_q + 12'd1;
               end
            end
            RX_DATA: begin
               if (cnt_q == clk_per_bit - 12'd1) begin
                  cnt_q   <= '0;
                  shift_q <= {rx_s, shift_q[7:1]};
                  bit_q   <= bit_q + 3'd1;
                  if (bit_q == 3'd7) state_q <= RX_STOP;
               end else begin
                  cnt_q <= cnt_q + 12'd1;
               end
            end
            RX_STOP: begin
               if (cnt_q == clk_per_bit - 12'd1) begin
                  cnt_q   <= '0;
                  state_q <= RX_IDLE;
                  if (rx_s) begin
                     ready_q <= 1'b1;
                     byte_q  <= shift_q;
                  end
               end else begin
                  cnt_q <= cnt_q + 12'd1;
               end
            end
            default: state_q <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/usart_rx_fifo_bamse.sv
// rtl/usart_rx_fifo_bamse.sv - buffered USART receive port: decode, overrun, threshold irq, read mux
module usart_rx_fifo_bamse
   import usart_pkg::*;
#(
   parameter logic [7:0] ADDR      = 8'h00,
   parameter logic [7:0] STAT_ADDR = 8'h01,
   parameter int         DEPTH     = 8,
   parameter int         THRESH    = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx,
   input  logic [11:0] clk_per_bit,
   input  logic [7:0]  address,
   input  logic        ren,
   output logic [7:0]  port_out,
   output logic        int_rx
);

   logic       rx_ready;
   logic [7:0] rx_byte;
   logic [7:0] head;
   logic       full, empty;
   logic [4:0] count, count_next;
   logic       pop_req, pop_fire, stat_rd;
   logic       overrun_q, overrun_d;
   logic       int_rx_q;
   logic [7:0] status;

   uart_rx u_uart_rx (
      .clk         (clk),
      .rst         (rst),
      .rx          (rx),
      .clk_per_bit (clk_per_bit),
      .rx_ready    (rx_ready),
      .rx_byte     (rx_byte)
   );

   rx_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_rx_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (rx_ready),
      .wdata      (rx_byte),
      .pop        (pop_req),
      .rdata      (head),
      .full       (full),
      .empty      (empty),
      .count      (count),
      .count_next (count_next)
   );

   assign pop_req  = ren && (address == ADDR);
   assign pop_fire = pop_req && !empty;
   assign stat_rd  = ren && (address == STAT_ADDR);

   // Setting wins over the read-to-clear so a same-cycle overrun is never lost.
   always_comb begin
      overrun_d = overrun_q;
      if (rx_ready && full && !pop_fire) overrun_d = 1'b1;
      else if (stat_rd)                  overrun_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         overrun_q <= 1'b0;
         int_rx_q  <= 1'b0;
      end else begin
         overrun_q <= overrun_d;
         int_rx_q  <= (count_next >= 5'(THRESH));
      end
   end

   assign int_rx = int_rx_q;

   always_comb begin
      status                      = '0;
      status[ST_OVR]              = overrun_q;
      status[ST_FULL]             = full;
      status[ST_EMPTY]            = empty;
      status[ST_CNT_HI:ST_CNT_LO] = count;
   end

   always_comb begin
      port_out = 8'h00;
      if (address == ADDR)           port_out = empty ? 8'h00 : head;
      else if (address == STAT_ADDR) port_out = status;
   end

endmodule

// File: tb/tb_usart_rx_fifo_bamse.sv
// tb/tb_usart_rx_fifo_bamse.sv - two DUTs (threshold 1 and 4) on shared stimulus, queue model plus literals
module tb_usart_rx_fifo_bamse;

   logic        clk;
   logic        rst;
   logic        rx;
   logic [11:0] cpb;
   logic [7:0]  address;
   logic        ren;
   logic [7:0]  port_out_a, port_out_b;
   logic        int_a, int_b;

   int n_chk;
   int n_fail;

   logic [7:0] sent_log [256];
   int         sent_n;

   logic       rdy_w  [2];
   logic [7:0] pout_w [2];
   logic       int_w  [2];

   usart_rx_fifo_bamse #(.ADDR(8'h00), .STAT_ADDR(8'h01), .DEPTH(8), .THRESH(1)) u_dut_a (
      .clk(clk), .rst(rst), .rx(rx), .clk_per_bit(cpb), .address(address),
      .ren(ren), .port_out(port_out_a), .int_rx(int_a)
   );

   usart_rx_fifo_bamse #(.ADDR(8'h00), .STAT_ADDR(8'h01), .DEPTH(8), .THRESH(4)) u_dut_b (
      .clk(clk), .rst(rst), .rx(rx), .clk_per_bit(cpb), .address(address),
      .ren(ren), .port_out(port_out_b), .int_rx(int_b)
   );

   assign rdy_w[0]  = u_dut_a.rx_ready;
   assign rdy_w[1]  = u_dut_b.rx_ready;
   assign pout_w[0] = port_out_a;
   assign pout_w[1] = port_out_b;
   assign int_w[0]  = int_a;
   assign int_w[1]  = int_b;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: a byte queue per DUT, fed by the bytes the bench sent.
   for (genvar gi = 0; gi < 2; gi++) begin : g_mdl
      localparam int TH = (gi == 0) ? 1 : 4;
      logic [7:0] mq [$];
      logic [7:0] tmp;
      logic [7:0] exp_po;
      bit         ovr, intr, ovr_set, started;
      int         rd_idx;

      initial begin
         ovr = 0; intr = 0; started = 0; rd_idx = 0;
      end

      always @(posedge clk) begin
         started = 1;
         if (rst) begin
            mq.delete();
            ovr    = 0;
            intr   = 0;
            rd_idx = sent_n;
         end else begin
            ovr_set = 0;
            if (ren && address == 8'h00 && mq.size() > 0) tmp = mq.pop_front();
            if (rdy_w[gi]) begin
               if (rd_idx >= sent_n) begin
                  check("spurious_rx_ready", 8'd1, 8'd0);
               end else begin
                  tmp = sent_log[rd_idx];
                  rd_idx++;
                  if (mq.size() < 8) mq.push_back(tmp);
                  else ovr_set = 1;
               end
            end
            if (ovr_set) ovr = 1;
            else if (ren && address == 8'h01) ovr = 0;
            intr = (mq.size() >= TH);
         end
      end

      always @(negedge clk) begin
         if (started) begin
            if (address == 8'h00)
               exp_po = (mq.size() > 0) ? mq[0] : 8'h00;
            else if (address == 8'h01)
               exp_po = {ovr, mq.size() == 8, mq.size() == 0, 5'(mq.size())};
            else
               exp_po = 8'h00;
            check($sformatf("model_port_out[%0d]", gi), pout_w[gi], exp_po);
            check($sformatf("model_int_rx[%0d]", gi), {7'd0, int_w[gi]}, {7'd0, intr});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      sent_log[sent_n] = b;
      sent_n++;
      rx = 1'b0;
      repeat (cpb) tick();
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (cpb) tick();
      end
      rx = 1'b1;
      repeat (cpb) tick();
      repeat (4) tick();
   endtask

   task automatic peek(input logic [7:0] a, input logic [7:0] exp, input string nm);
      address = a;
      #1;
      check({nm, "_a"}, port_out_a, exp);
      check({nm, "_b"}, port_out_b, exp);
   endtask

   task automatic pop_chk(input logic [7:0] exp, input string nm);
      address = 8'h00;
      ren     = 1'b1;
      #1;
      check({nm, "_a"}, port_out_a, exp);
      check({nm, "_b"}, port_out_b, exp);
      tick();
      ren = 1'b0;
   endtask

   task automatic chk_int(input logic ea, input logic eb, input string nm);
      check({nm, "_int_a"}, {7'd0, int_a}, {7'd0, ea});
      check({nm, "_int_b"}, {7'd0, int_b}, {7'd0, eb});
   endtask

   initial begin
      #20_000_000;
      $display("FAIL watchdog: got timeout expected finish at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      n_chk = 0; n_fail = 0; sent_n = 0;
      rst = 1'b1; rx = 1'b1; cpb = 12'd104; address = 8'h00; ren = 1'b0;
      repeat (5) tick();
      rst = 1'b0;
      tick();
      peek(8'h00, 8'h00, "reset_data");
      peek(8'h01, 8'h20, "reset_stat");
      peek(8'h07, 8'h00, "other_addr");
      chk_int(1'b0, 1'b0, "reset");

      // single byte at 115200 baud / 12 MHz
      send(8'h55);
      peek(8'h01, 8'h01, "one_byte_stat");
      chk_int(1'b1, 1'b0, "one_byte");
      pop_chk(8'h55, "one_byte_pop");
      chk_int(1'b0, 1'b0, "one_byte_after_pop");
      peek(8'h01, 8'h20, "one_byte_empty");

      // nine bytes into eight slots
      for (int i = 1; i <= 9; i++) send(8'(i));
      peek(8'h01, 8'hC8, "overrun_stat");
      ren = 1'b1;
      #1;
      check("overrun_stat_read_a", port_out_a, 8'hC8);
      tick();
      ren = 1'b0;
      peek(8'h01, 8'h48, "overrun_cleared");
      for (int i = 1; i <= 8; i++) pop_chk(8'(i), "overrun_pop");
      peek(8'h01, 8'h20, "overrun_drained");
      peek(8'h00, 8'h00, "overrun_no_ninth");

      // threshold 4 on DUT b
      for (int i = 0; i < 3; i++) send(8'h31 + 8'(i));
      chk_int(1'b1, 1'b0, "thresh_three");
      send(8'h34);
      chk_int(1'b1, 1'b1, "thresh_four");
      pop_chk(8'h31, "thresh_pop");
      chk_int(1'b1, 1'b0, "thresh_below");
      for (int i = 2; i <= 4; i++) pop_chk(8'h30 + 8'(i), "thresh_drain");

      // full FIFO with a pop in the rx_ready cycle
      for (int i = 0; i < 8; i++) send(8'h10 + 8'(i));
      found = 0;
      fork
         send(8'hA5);
         begin
            for (int k = 0; k < 12 * 104; k++) begin
               @(negedge clk);
               if (u_dut_a.rx_ready) begin
                  found = 1;
                  break;
               end
            end
            if (found) begin
               address = 8'h00;
               ren     = 1'b1;
               @(posedge clk);
               #1;
               ren = 1'b0;
            end
         end
      join
      check("concurrent_pop_seen", {7'd0, found}, 8'd1);
      peek(8'h01, 8'h48, "concurrent_stat");
      for (int i = 1; i < 8; i++) pop_chk(8'h10 + 8'(i), "concurrent_pop");
      pop_chk(8'hA5, "concurrent_last");
      peek(8'h01, 8'h20, "concurrent_empty");

      // pop on empty, then reset mid-frame
      pop_chk(8'h00, "empty_pop");
      peek(8'h01, 8'h20, "empty_pop_stat");
      for (int i = 0; i < 3; i++) send(8'h61 + 8'(i));
      peek(8'h01, 8'h03, "pre_reset_stat");
      fork
         send(8'h64);
         begin
            repeat (3 * 104) tick();
            rst = 1'b1;
         end
      join
      peek(8'h01, 8'h20, "in_reset_stat");
      chk_int(1'b0, 1'b0, "in_reset");
      rst = 1'b0;
      repeat (3) tick();
      peek(8'h01, 8'h20, "post_reset_stat");
      chk_int(1'b0, 1'b0, "post_reset");

      // pointer wrap: 20 push/pop pairs
      for (int i = 0; i < 20; i++) begin
         send(8'h80 + 8'(i));
         peek(8'h01, 8'h01, "wrap_stat");
         pop_chk(8'h80 + 8'(i), "wrap_pop");
      end
      peek(8'h01, 8'h20, "wrap_end");

      repeat (4) tick();
      check("all_bytes_seen_a", 8'(g_mdl[0].rd_idx), 8'(sent_n));
      check("all_bytes_seen_b", 8'(g_mdl[1].rd_idx), 8'(sent_n));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/usart_rx_fifo_bamse.md
# usart_rx_fifo_bamse

Buffered, parametrised USART receive port for the BAMSE bus. It contains the existing `uart_rx` serial receiver and a first-word-fall-through byte FIFO of configurable depth, so the CPU can fetch several received bytes per interrupt instead of one. It also provides a status register, a sticky overrun flag and a programmable interrupt threshold. It sits between the asynchronous `rx` pin and the BAMSE read-data mux, one instance per UART channel.

## Interface
- `ADDR`, 8'h00, BAMSE address of the data (FIFO pop) register
- `STAT_ADDR`, 8'h01, BAMSE address of the status register; must differ from `ADDR`
- `DEPTH`, 8, FIFO entries; power of two, 2..16
- `THRESH`, 1, fill level at which `int_rx` asserts; 1..`DEPTH`
- `clk`  input  1  system clock
- `rst`  input  1  synchronous, active-high reset
- `rx`  input  1  asynchronous serial input, idle high
- `clk_per_bit`  input  12  clk cycles per bit (clk_freq / baud), from CONFIG_UART_RX
- `address`  input  8  BAMSE read address
- `ren`  input  1  BAMSE read enable, one cycle per access
- `port_out`  output  8  read data, combinational from `address`
- `int_rx`  output  1  level interrupt, registered

## Operation
- The receiver pulses `rx_ready` for one cycle with `rx_byte` valid. That byte is written (pushed) to the FIFO tail.
- Push when full: the byte is discarded, `overrun` is set (sticky), and FIFO contents are unchanged.
- Pop condition: `ren && address==ADDR && !empty`. The head pointer advances.
- A pop condition with the FIFO empty has no effect: no pointer change, no flag change.
- Push and pop in the same cycle: both take effect and `count` is unchanged.
- Push and pop in the same cycle while full: the pop makes room, the byte is accepted, and `overrun` is not set.
- Status byte: bit7 `overrun`, bit6 `full`, bit5 `empty`, bits4:0 `count`. `count` ranges 0..`DEPTH`.
- Status read (`ren && address==STAT_ADDR`): returns the pre-clear value and clears `overrun` at the next edge.
  - If an overrun occurs in that same cycle, `overrun` stays set, because set wins over clear.
- `port_out` mux:
  - `address==ADDR`: FIFO head, or 8'h00 when empty.
  - `address==STAT_ADDR`: status byte.
  - Any other address: 8'h00.
  - The mux is independent of `ren`.
- `int_rx` is a flop loaded each cycle with `count_next >= THRESH`. It therefore drops at the edge where the pop brings `count` below `THRESH`.
- Pointers are log2(`DEPTH`) bits and wrap modulo `DEPTH`. `count` is held separately, 5 bits wide.

## Timing
- Reset values: pointers 0, `count` 0, `overrun` 0, `int_rx` 0, `port_out` = 8'h00 at `ADDR` / 8'h20 at `STAT_ADDR`.
- Reset also resets the receiver. A byte arriving serially during reset is lost, with no overrun.
- Byte latency: `rx_ready` cycle N → entry visible on `port_out` and in `count` at cycle N+1.
  - `int_rx` rises at cycle N+1 if the threshold is crossed.
- Pop: data is read combinationally in the `ren` cycle. The next entry appears in cycle +1.
- Back-to-back pops, one per cycle, are legal.

## Structure
- Shared package `usart_pkg` defines:
  - Status bit positions: `ST_OVR`=7, `ST_FULL`=6, `ST_EMPTY`=5, `ST_CNT` = [4:0].
  - The pointer-width function clog2.
- Natural sub-modules:
  - `rx_fifo`: synchronous FWFT FIFO with DEPTH/WIDTH parameters, push/pop/full/empty/count.
  - The existing `uart_rx` receiver, instantiated unchanged.
- The top level holds the address decode, the overrun flag, the threshold compare and the output mux.

## Test plan
- Baud 115200 at 12 MHz (`clk_per_bit`=104), send 0x55 → `int_rx` high 1 cycle after `rx_ready`. Status reads 8'h01. Read `ADDR` → 0x55. Then `int_rx` low and status 8'h20.
- DEPTH=8: send 0x01..0x09 without reads.
  - Status reads 8'hC8.
  - Eight pops return 0x01..0x08 and 0x09 is absent.
  - After the first status read, bit7 is clear.
- THRESH=4: send 3 bytes → `int_rx` stays 0. Send the 4th → `int_rx`=1. Pop once → `int_rx`=0 the next cycle.
- Full FIFO: force a pop in the same cycle as `rx_ready` of 0xA5 → no overrun, `count` stays 8, and 0xA5 is read last.
- Pop on empty FIFO: `port_out`=0x00, status unchanged at 8'h20. Then assert `rst` mid-frame with 3 bytes queued → status 8'h20 and `int_rx`=0 after the reset edge.
- Wrap-around: 20 push/pop pairs at DEPTH=8 → data order preserved across pointer wrap, and `count` never exceeds 1.
